// File: rtl/fifo_vc_pkg.sv
// Shared sizing for the pop-delay buffer stage, the virtual-channel FIFOs and the output muxes.
// Also classifies a cycle's accepted accesses so count updates read as a single decode.
package fifo_vc_pkg;

    localparam int VC_DATA_WIDTH  = 6;
    localparam int VC_ADDR_WIDTH  = 4;
    localparam int VC_UMBRAL_ALTO = 12;
    localparam int VC_UMBRAL_BAJO = 3;

    // Encoding is {push_accepted, pop_accepted} so the enum can be built by a cast.
    typedef enum logic [1:0] {
        ACC_IDLE = 2'b00,
        ACC_POP  = 2'b01,
        ACC_PUSH = 2'b10,
        ACC_BOTH = 2'b11
    } acc_e;

    function automatic acc_e classify_access(input logic push_acc, input logic pop_acc);
        return acc_e'({push_acc, pop_acc});
    endfunction

endpackage

// File: rtl/fifo_vc_mem_2p.sv
// One-write/one-read storage array with synchronous write and a registered synchronous read port.
// The read register doubles as the FIFO's data_out.
module mem_2p #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset so it maps onto plain RAM; stale words are unreachable after reset because the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-address write and read in one cycle returns the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_vc.sv
// Virtual-channel FIFO fed by the pop-delay buffer: count-based full/empty, programmable
// almost-full/almost-empty thresholds and a one-cycle error pulse on illegal accesses.
module fifo_vc
    import fifo_vc_pkg::*;
#(
    parameter int DATA_WIDTH  = VC_DATA_WIDTH,
    parameter int ADDR_WIDTH  = VC_ADDR_WIDTH,
    parameter int UMBRAL_ALTO = VC_UMBRAL_ALTO,
    parameter int UMBRAL_BAJO = VC_UMBRAL_BAJO
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int                  DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] HIGH_CNT = (ADDR_WIDTH+1)'(UMBRAL_ALTO);
    localparam logic [ADDR_WIDTH:0] LOW_CNT  = (ADDR_WIDTH+1)'(UMBRAL_BAJO);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push_acc;
    logic                  pop_acc;
    logic                  err_nxt;
    acc_e                  acc;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= HIGH_CNT);
    assign almost_empty = (count <= LOW_CNT);

    // NOTE: every output of this block is assigned first so no path can leave one unassigned and infer a latch.
    always_comb begin
        pop_acc  = pop & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_acc = push & (~full | pop_acc);
        err_nxt  = (push & full & ~pop_acc) | (pop & empty);
        acc      = classify_access(push_acc, pop_acc);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            case (acc)
                ACC_PUSH: count <= count + 1'b1;
                ACC_POP:  count <= count - 1'b1;
                default:  count <= count;
            endcase
            valid_out <= pop_acc;
            error     <= err_nxt;
        end
    end

    mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset_L (reset_L),
        .we      (push_acc & reset_L),
        .waddr   (wr_ptr),
        .wdata   (data_in),
        .re      (pop_acc & reset_L),
        .raddr   (rd_ptr),
        .rdata   (data_out)
    );

endmodule

// File: tb/tb_fifo_vc.sv
// Self-checking bench for fifo_vc: directed scenarios plus random traffic, all compared
// against a queue-based model of the FIFO's visible behaviour.
module tb_fifo_vc;

    localparam int DW    = 6;
    localparam int DEPTH = 16;
    localparam int HI    = 12;
    localparam int LO    = 3;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_err;

    fifo_vc dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    function automatic logic [DW+5:0] observed();
        return {data_out, valid_out, error, full, empty, almost_full, almost_empty};
    endfunction

    function automatic logic [DW+5:0] expected();
        int n = q.size();
        return {exp_data, exp_valid, exp_err, n == DEPTH, n == 0, n >= HI, n <= LO};
    endfunction

    // One clock: drive on the falling edge, update the model at the rising edge, settle 1 ns.
    task automatic step(input logic rst, input logic p, input logic [DW-1:0] d, input logic po);
        int  n;
        logic pop_ok;
        logic push_ok;
        @(negedge clk);
        reset_L = rst;
        push    = p;
        data_in = d;
        pop     = po;
        @(posedge clk);
        n = q.size();
        if (!rst) begin
            q.delete();
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            pop_ok  = po && n > 0;
            push_ok = p && (n < DEPTH || pop_ok);
            exp_err = (p && n == DEPTH && !pop_ok) || (po && n == 0);
            exp_valid = pop_ok;
            if (pop_ok) exp_data = q.pop_front();
            if (push_ok) q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (observed() !== expected() || !empty || !almost_empty || data_out !== '0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            step(1'b1, 1'b1, DW'(i), 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL fill[%0d]: got %h expected %h", i, observed(), expected());
            end
        end
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (observed() !== expected() || error !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_error_pulse: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL drain[%0d]: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 1'b1, DW'($urandom), 1'b0);
                checks++;
                if (observed() !== expected()) begin
                    errors++;
                    $display("FAIL wrap_push[%0d.%0d]: got %h expected %h", r, i, observed(), expected());
                end
            end
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 1'b0, '0, 1'b1);
                checks++;
                if (observed() !== expected()) begin
                    errors++;
                    $display("FAIL wrap_pop[%0d.%0d]: got %h expected %h", r, i, observed(), expected());
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        while (q.size() < DEPTH) step(1'b1, 1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, DW'($urandom), 1'b1);
            checks++;
            if (observed() !== expected() || !full || error) begin
                errors++;
                $display("FAIL both_full[%0d]: got %h expected %h", i, observed(), expected());
            end
        end
        while (q.size() > 0) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, DW'($urandom), 1'b1);
        checks++;
        if (observed() !== expected() || !error || valid_out || empty) begin
            errors++;
            $display("FAIL both_empty: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'b1, $urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 45);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] fresh;
        while (q.size() > 0) step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, DW'(i + 40), 1'b0);
        step(1'b0, 1'b1, DW'(63), 1'b1);
        checks++;
        if (observed() !== expected() || !empty || valid_out) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", observed(), expected());
        end
        fresh = DW'(21);
        step(1'b1, 1'b1, fresh, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (observed() !== expected() || data_out !== fresh || !valid_out) begin
            errors++;
            $display("FAIL reset_mid_fresh: got %h expected %h", observed(), expected());
        end
    endtask

    initial begin
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
